rr_arbiter_n: RTL and testbench

Parametrised N-requester round-robin arbiter with burst hold. A grant stays with one requester for up to HOLD_MAX beats, or until that requester signals its last beat or drops its request. It then rotates to the next requester, with no idle cycle between grants when other requests are pending. It sits in front of shared datapath resources (bus, memory port) in the same subsystems that use the 3-way single-beat arbiter; HOLD_MAX=1 reproduces single-beat fair arbitration for any N.

---
 rtl/rr_arb_pkg.sv | 40 ++++
 rtl/rr_arb_pick.sv | 31 +++
 rtl/rr_arbiter_n.sv | 107 ++++++++++
 tb/tb_rr_arbiter_n.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared types, width helpers and the cyclic pick function for rr_arbiter_n
package rr_arb_pkg;

    typedef enum logic {IDLE, BUSY} state_e;

    localparam int MAX_REQ   = 64;
    localparam int MAX_IDX_W = 6;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } pick_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int hold);
        return $clog2(hold + 1);
    endfunction

    // First set bit of req_vec searched cyclically from ptr; lower offsets overwrite higher ones.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req_vec, input int ptr, input int n);
        pick_t r;
        int    j;
        r = '0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                j = ptr + k;
                if (j >= n) j = j - n;
                if (req_vec[j]) begin
                    r.found = 1'b1;
                    r.idx   = j[MAX_IDX_W-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// rr_arb_pick: combinational rotate-and-priority-encode of N_REQ request bits starting at ptr
module rr_arb_pick
    import rr_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_vec,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx,
    output logic [N_REQ-1:0] onehot
);

    pick_t p;

    // Search from ptr, then narrow the package-wide index down to this instance's width and one-hot form
    always_comb begin
        p      = rr_pick(MAX_REQ'(req_vec), int'(ptr), N_REQ);
        found  = p.found;
        idx    = '0;
        onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (p.idx == MAX_IDX_W'(i)) begin
                idx       = IDX_W'(i);
                onehot[i] = p.found;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n: N-requester round-robin arbiter with burst hold (optional RR_ARB_PRIO_EN adds hi_prio filtering)
module rr_arbiter_n
    import rr_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int HOLD_MAX = 4,
    parameter int IDX_W    = idx_w(N_REQ)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] req_last,
`ifdef RR_ARB_PRIO_EN
    input  logic [N_REQ-1:0] hi_prio,
`endif
    output logic [N_REQ-1:0] grant,
    output logic             grant_vld,
    output logic [IDX_W-1:0] grant_idx
);

    localparam int CNT_W = cnt_w(HOLD_MAX);

    state_e           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             vld_q, vld_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] nxt_ptr, pick_ptr, win_idx;
    logic [N_REQ-1:0] pick_vec, win_oh;
    logic             win_found, release_c;

`ifdef RR_ARB_PRIO_EN
    assign pick_vec = |(req & hi_prio) ? (req & hi_prio) : req;
`else
    assign pick_vec = req;
`endif

    assign nxt_ptr   = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
    assign pick_ptr  = (state_q == BUSY) ? nxt_ptr : ptr_q;
    assign release_c = !en || !req[idx_q] || req_last[idx_q] || (cnt_q == CNT_W'(HOLD_MAX));

    rr_arb_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .req_vec (pick_vec),
        .ptr     (pick_ptr),
        .found   (win_found),
        .idx     (win_idx),
        .onehot  (win_oh)
    );

    // Grant FSM: first grant from IDLE, hold/count in BUSY, zero-bubble handover on release
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        vld_d   = vld_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            if (en && win_found) begin
                state_d = BUSY;
                grant_d = win_oh;
                vld_d   = 1'b1;
                idx_d   = win_idx;
                cnt_d   = CNT_W'(1);
            end
        end else if (!en) begin
            state_d = IDLE;
            grant_d = '0;
            vld_d   = 1'b0;
        end else if (release_c) begin
            state_d = win_found ? BUSY : IDLE;
            grant_d = win_oh;
            vld_d   = win_found;
            idx_d   = win_found ? win_idx : idx_q;
            ptr_d   = nxt_ptr;
            cnt_d   = CNT_W'(1);
        end else begin
            cnt_d   = cnt_q + 1'b1;
        end
    end

    // State and registered outputs, cleared asynchronously
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            grant_q <= '0;
            vld_q   <= 1'b0;
            idx_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            vld_q   <= vld_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant     = grant_q;
    assign grant_vld = vld_q;
    assign grant_idx = idx_q;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// tb_rr_arbiter_n: scoreboard bench for rr_arbiter_n against a queue-fed behavioural model
module tb_rr_arbiter_n;

    localparam int N = 4;
    localparam int H = 4;

    logic         clk = 1'b0;
    logic         rstn;
    logic         en;
    logic [N-1:0] req;
    logic [N-1:0] req_last;
`ifdef RR_ARB_PRIO_EN
    logic [N-1:0] hi_prio;
`endif
    logic [N-1:0] grant;
    logic         grant_vld;
    logic [1:0]   grant_idx;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [N-1:0] g;
        logic         v;
        logic [1:0]   i;
    } exp_t;

    exp_t exp_q[$];

    int m_holder, m_ptr, m_beats, m_idx;

    rr_arbiter_n #(.N_REQ(N), .HOLD_MAX(H)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .en        (en),
        .req       (req),
        .req_last  (req_last),
`ifdef RR_ARB_PRIO_EN
        .hi_prio   (hi_prio),
`endif
        .grant     (grant),
        .grant_vld (grant_vld),
        .grant_idx (grant_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic int mpick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] eff_req();
`ifdef RR_ARB_PRIO_EN
        return ((req & hi_prio) != 0) ? (req & hi_prio) : req;
`else
        return req;
`endif
    endfunction

    // Reference model: who holds the grant after each edge, from the arbitration rules directly
    always @(posedge clk or negedge rstn) begin
        exp_t e;
        if (!rstn) begin
            m_holder = -1;
            m_ptr    = 0;
            m_beats  = 0;
            m_idx    = 0;
            exp_q.delete();
        end else begin
            if (m_holder < 0) begin
                if (en && req != 0) begin
                    m_holder = mpick(eff_req(), m_ptr);
                    m_beats  = 1;
                end
            end else if (!en) begin
                m_holder = -1;
            end else if (!req[m_holder] || req_last[m_holder] || m_beats == H) begin
                m_ptr    = (m_holder + 1) % N;
                m_holder = mpick(eff_req(), m_ptr);
                m_beats  = 1;
            end else begin
                m_beats++;
            end
            if (m_holder >= 0) m_idx = m_holder;
            e.g = (m_holder >= 0) ? N'(1) << m_holder : '0;
            e.v = (m_holder >= 0);
            e.i = 2'(m_idx);
            exp_q.push_back(e);
        end
    end

    // Monitor: compare every presented output cycle against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("grant", int'(grant), int'(e.g));
            chk("grant_vld", int'(grant_vld), int'(e.v));
            chk("grant_idx", int'(grant_idx), int'(e.i));
            chk("onehot0", int'($onehot0(grant)), 1);
        end
    end

    task automatic step(input logic e, input logic [N-1:0] r, input logic [N-1:0] l);
        en       = e;
        req      = r;
        req_last = l;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        @(posedge clk);
        #2;
        rstn = 1'b1;
    endtask

    initial begin
        logic [N-1:0] r;
        rstn     = 1'b0;
        en       = 1'b0;
        req      = '0;
        req_last = '0;
`ifdef RR_ARB_PRIO_EN
        hi_prio  = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("reset_grant", int'(grant), 0);
        chk("reset_vld", int'(grant_vld), 0);
        chk("reset_idx", int'(grant_idx), 0);
        #1;
        rstn = 1'b1;
        // full rotation with hold
        for (int c = 0; c < 20; c++) step(1'b1, 4'b1111, 4'b0000);
        // single requester re-granted every beat with last asserted
        for (int c = 0; c < 6; c++) step(1'b1, 4'b0100, 4'b1111);
        // early last on requester 0
        for (int c = 0; c < 10; c++) step(1'b1, 4'b1001, 4'b0001);
        // enable drop mid-burst, ptr stays at 0
        do_reset();
        for (int c = 0; c < 3; c++) step(1'b1, 4'b0010, 4'b0000);
        for (int c = 0; c < 2; c++) step(1'b0, 4'b0010, 4'b0000);
        for (int c = 0; c < 4; c++) step(1'b1, 4'b0011, 4'b0000);
        // asynchronous reset mid-burst
        do_reset();
        for (int c = 0; c < 10; c++) step(1'b1, 4'b1111, 4'b0000);
        #1;
        rstn = 1'b0;
        #1;
        chk("async_grant", int'(grant), 0);
        chk("async_vld", int'(grant_vld), 0);
        chk("async_idx", int'(grant_idx), 0);
        @(posedge clk);
        #2;
        rstn = 1'b1;
        for (int c = 0; c < 6; c++) step(1'b1, 4'b1111, 4'b0000);
`ifdef RR_ARB_PRIO_EN
        do_reset();
        hi_prio = 4'b1000;
        for (int c = 0; c < 6; c++) step(1'b1, 4'b1111, 4'b0000);
        hi_prio = 4'b0000;
        for (int c = 0; c < 4; c++) step(1'b1, 4'b1111, 4'b0000);
`endif
        // randomized traffic
        r = 4'b1111;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) == 0) r = N'($urandom);
`ifdef RR_ARB_PRIO_EN
            if ($urandom_range(0, 7) == 0) hi_prio = N'($urandom);
`endif
            step($urandom_range(0, 9) != 0, r, ($urandom_range(0, 3) == 0) ? N'($urandom) : '0);
        end
        for (int c = 0; c < 3; c++) step(1'b0, 4'b0000, 4'b0000);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
